// File: rtl/rnn_preact_mac.sv
// Streaming signed dot-product accumulator: z = bias + sum(a*b), emitted as saturated Q8.8.
// Build option: define PREACT_ROUND_EN to round half toward +inf instead of truncating.
module rnn_preact_mac #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 40,
  parameter int MAX_LEN = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  input  logic [DATA_W-1:0] bias_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic              out_len_err
);

  // state | meaning
  // IDLE  | waiting for the first beat of a vector; bias sampled on that beat
  // ACC   | accumulating further beats until in_last or MAX_LEN
  // OUT   | result held on out_* until out_ready

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int RW = ACC_W + 1 - 8;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0]         acc, acc_nxt;
  logic [CW-1:0]            cnt, cnt_nxt;
  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]         prod_ext, bias_ext;
  logic                     beat, at_max, vec_done;
  logic [ACC_W:0]           acc_rnd;
  logic [RW-1:0]            r;
  logic                     pos_ovf, neg_ovf;
  logic [DATA_W-1:0]        sat_data;
  logic                     unused_frac;

  assign prod     = $signed(in_a) * $signed(in_b);
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  // Q8.8 bias aligned to the Q16.16 accumulator
  assign bias_ext = {{(ACC_W-DATA_W-8){bias_in[DATA_W-1]}}, bias_in, 8'h00};

  assign beat     = in_valid & in_ready;
  assign cnt_nxt  = (state == IDLE) ? CW'(1) : cnt + CW'(1);
  assign acc_nxt  = ((state == IDLE) ? bias_ext : acc) + prod_ext;
  assign at_max   = (cnt_nxt == CW'(MAX_LEN));
  assign vec_done = beat & (in_last | at_max);

`ifdef PREACT_ROUND_EN
  assign acc_rnd = {acc_nxt[ACC_W-1], acc_nxt} + (ACC_W+1)'(128);
`else
  assign acc_rnd = {acc_nxt[ACC_W-1], acc_nxt};
`endif

  // Arithmetic >>>8 by bit selection; the fraction bits below Q8.8 are dropped
  assign r           = acc_rnd[ACC_W:8];
  assign unused_frac = ^acc_rnd[7:0];

  assign pos_ovf  = ~r[RW-1] & (|r[RW-2:DATA_W-1]);
  assign neg_ovf  = r[RW-1] & ~(&r[RW-2:DATA_W-1]);
  assign sat_data = pos_ovf ? {1'b0, {(DATA_W-1){1'b1}}} :
                    neg_ovf ? {1'b1, {(DATA_W-1){1'b0}}} :
                              r[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (vec_done)  state_nxt = OUT;
        else if (beat) state_nxt = ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        if (vec_done) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc         <= '0;
      cnt         <= '0;
      out_data    <= '0;
      out_sat     <= 1'b0;
      out_len_err <= 1'b0;
    end else if (beat) begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      if (vec_done) begin
        out_data    <= sat_data;
        out_sat     <= pos_ovf | neg_ovf;
        out_len_err <= at_max & ~in_last;
      end
    end
  end

endmodule
